mod_addsub_pipe: RTL
====================

Name: mod_addsub_pipe

Overview:
- Multi-lane, two-stage pipelined modular add/subtract/accumulate unit with valid/ready flow control on both sides.
- Generalised successor of the single-lane registered modular adder: adds lane count, subtract, per-lane accumulators, backpressure and a defined modulus-zero mode.
- Sits between operand sources (NTT/RNS datapaths) and downstream consumers that may stall.

Parameters:
- BITWIDTH, 32, width of each lane operand, modulus and result.
- LANES, 4, number of independent lanes sharing one modulus and one opcode.

Ports:
- iClk  in  1  clock, all state on rising edge.
- iRstN  in  1  asynchronous active-low reset.
- iClr  in  1  synchronous clear: pipeline valids and accumulators to 0.
- iValid  in  1  input transaction valid.
- oReady  out  1  unit can accept a transaction this cycle.
- iOp  in  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- iMod  in  BITWIDTH  modulus, captured with the transaction; 0 means 2^BITWIDTH.
- iData0  in  LANES*BITWIDTH  operand A, lane i at bits [i*BITWIDTH +: BITWIDTH].
- iData1  in  LANES*BITWIDTH  operand B, same packing; ignored for ACC/LOAD.
- oValid  out  1  output result valid.
- iReady  in  1  downstream accepts result.
- oData  out  LANES*BITWIDTH  result, same packing.

Behaviour:
- Reset (iRstN low, async): stage valids 0, oValid 0, oData 0, all accumulators 0, stage-1 registers 0.
- Transfer in when iValid && oReady; transfer out when oValid && iReady.
- Stage 1 (S1): registers op, modulus, operands. Stage 2 (S2): computes and registers oData/oValid.
- Latency: 2 cycles from accepted input to oValid with iReady high; throughput 1 per cycle.
- S2 loads when S1 valid and (!oValid || iReady). S1 loads when (!S1valid || S2 loads).
- oReady = !S1valid || !oValid || iReady (combinational from iReady; no other comb path).
- Stalled stages hold contents; oData stable while oValid && !iReady.
- Extended modulus Mx = (iMod==0) ? 2^BITWIDTH : iMod, BITWIDTH+1 bits.
- ADD: s = a + b (BITWIDTH+1 bits); result = (s >= Mx) ? s - Mx : s.
- SUB: result = (a >= b) ? a - b : a - b + Mx, truncated to BITWIDTH.
- ACC: result = (acc_i + a) reduced as ADD; acc_i <= result.
- LOAD: acc_i <= a; result = a, no reduction.
- Accumulator read and written in S2 on the S2 load edge, so back-to-back ACC/LOAD need no bubbles and see the previous update.
- Precondition: operands and acc < Mx. Out-of-range operands give an unspecified result with no lockup.
- iClr: clears S1/S2 valids, oValid and all accumulators next edge. Overrides a simultaneous transfer; the input offered that cycle is dropped. oData is left unchanged.
- Reset mid-operation discards in-flight transactions. There is no partial output.
- Lanes are fully independent except for the shared iOp/iMod.

Test Plan:
- BITWIDTH=8, LANES=2, M=13, ADD (10,7),(12,0) -> lane results 4,12 two cycles after accept; oValid for 1 cycle.
- M=13, SUB (3,5),(5,5) -> 11,0.
- M=0 ADD (200,100),(255,1) -> 44,0. M=0 SUB (1,2) -> 255.
- M=17, back-to-back LOAD 5, ACC 9, ACC 9, ACC 0 with no gaps -> outputs 5,14,6,6 on consecutive cycles.
- Backpressure: iReady held low 4 cycles while 4 ADDs are offered. Exactly 2 accepted, then oReady=0; oData held. On release, all 4 results emerge in order with no loss or duplication.
- iClr asserted with ACC in flight, then ACC 3 with M=17 -> output 3, oValid low the cycle after iClr. Async iRstN pulse mid-stream -> oValid, oData 0 immediately.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// Multi-lane, two-stage pipelined modular add/subtract/accumulate unit.
// S1 registers the transaction, S2 computes, updates the per-lane accumulators and holds the result.
module mod_addsub_pipe #(
   parameter int BITWIDTH = 32,
   parameter int LANES    = 4
) (
   input  logic                      iClk,
   input  logic                      iRstN,
   input  logic                      iClr,
   input  logic                      iValid,
   output logic                      oReady,
   input  logic [1:0]                iOp,
   input  logic [BITWIDTH-1:0]       iMod,
   input  logic [LANES*BITWIDTH-1:0] iData0,
   input  logic [LANES*BITWIDTH-1:0] iData1,
   output logic                      oValid,
   input  logic                      iReady,
   output logic [LANES*BITWIDTH-1:0] oData
);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ACC  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   localparam int XW = BITWIDTH + 1;

   logic                      s1Valid;
   logic [1:0]                s1Op;
   logic [BITWIDTH-1:0]       s1Mod;
   logic [LANES*BITWIDTH-1:0] s1A;
   logic [LANES*BITWIDTH-1:0] s1B;

   logic                      s2Load;
   logic                      accWrite;
   logic [XW-1:0]             modX;
   logic [LANES*BITWIDTH-1:0] result;

   assign s2Load   = s1Valid && (!oValid || iReady);
   assign oReady   = !s1Valid || !oValid || iReady;
   assign accWrite = s2Load && ((s1Op == OP_ACC) || (s1Op == OP_LOAD));

   // A zero modulus selects the full 2^BITWIDTH ring.
   assign modX = (s1Mod == '0) ? {1'b1, {BITWIDTH{1'b0}}} : {1'b0, s1Mod};

   // Stage 1: transaction capture. iClr drops whatever is offered in the same cycle.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         s1Valid <= 1'b0;
         s1Op    <= '0;
         s1Mod   <= '0;
         s1A     <= '0;
         s1B     <= '0;
      end else if (iClr) begin
         s1Valid <= 1'b0;
      end else if (oReady) begin
         s1Valid <= iValid;
         if (iValid) begin
            s1Op  <= iOp;
            s1Mod <= iMod;
            s1A   <= iData0;
            s1B   <= iData1;
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : gLane
      logic [BITWIDTH-1:0] laneA;
      logic [BITWIDTH-1:0] laneB;
      logic [BITWIDTH-1:0] addend;
      logic [BITWIDTH-1:0] accQ;
      logic [BITWIDTH-1:0] laneRes;
      logic [XW-1:0]       sum;
      logic [XW-1:0]       diff;

      assign laneA  = s1A[g*BITWIDTH +: BITWIDTH];
      assign laneB  = s1B[g*BITWIDTH +: BITWIDTH];
      assign addend = (s1Op == OP_ACC) ? accQ : laneB;
      assign sum    = {1'b0, laneA} + {1'b0, addend};
      assign diff   = {1'b0, laneA} - {1'b0, laneB};

      always_comb begin
         // NOTE: default first so every path assigns laneRes and no latch is inferred.
         laneRes = laneA;
         case (s1Op)
            OP_ADD, OP_ACC: laneRes = (sum >= modX) ? BITWIDTH'(sum - modX) : sum[BITWIDTH-1:0];
            OP_SUB:         laneRes = (laneA >= laneB) ? diff[BITWIDTH-1:0] : BITWIDTH'(diff + modX);
            default:        laneRes = laneA;
         endcase
      end

      assign result[g*BITWIDTH +: BITWIDTH] = laneRes;

      // Read and written on the S2 load edge, so back-to-back ACC/LOAD chain without bubbles.
      always_ff @(posedge iClk or negedge iRstN) begin
         if (!iRstN) begin
            // NOTE: accumulators are architectural state and must come up as zero, so they are reset.
            accQ <= '0;
         end else if (iClr) begin
            accQ <= '0;
         end else if (accWrite) begin
            accQ <= laneRes;
         end
      end
   end

   // Stage 2: result register; oData is held while stalled and untouched by iClr.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oValid <= 1'b0;
         oData  <= '0;
      end else if (iClr) begin
         oValid <= 1'b0;
      end else if (s2Load) begin
         oValid <= 1'b1;
         oData  <= result;
      end else if (iReady) begin
         oValid <= 1'b0;
      end
   end

endmodule
